// File: rtl/io_port_pkg.sv
// Shared register map for the bus I/O port: offsets inside the 4-byte window
// and the bit positions of the STATUS and CTRL registers.
// No logic; constants only.
package io_port_pkg;

    // Register offsets, taken from adr_bus[1:0]
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_TX_OVF      = 4;
    localparam int ST_RX_OVF      = 5;

    // CTRL bit positions
    localparam int CTRL_IRQ_EN_RX      = 0;
    localparam int CTRL_IRQ_EN_TXEMPTY = 1;
    localparam int CTRL_OVF_CLR        = 7;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered storage; head is always visible on dout.
// Latency: a pushed byte appears on dout the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens on the same edge.
//
// Ports: clk, n_reset (async active-low), push/din write side,
//        pop/dout read side, full/empty/count status.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];

    // A pop on the same edge frees the slot the push lands in; when full,
    // wr_q == rd_q, so the head is read out before it is overwritten.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            if (do_push) mem_q[wr_q] <= din;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_io_port.sv
// Memory-mapped byte I/O responder: DATA/STATUS/CTRL window over a TX and an RX FIFO.
// Latency: bus reads return on data_out/data_oe registered at the addressing posedge.
// Backpressure: TX drained via tx_valid/tx_ready; RX has none, overflow drops and flags.
//
// Ports: clk, n_reset; CPU bus adr_bus/RW/data_in/data_out/data_oe;
//        TX stream tx_data/tx_valid/tx_ready; RX input rx_data/rx_strobe; irq.
module bus_io_port
    import io_port_pkg::*;
#(
    parameter logic [15:0] BASE_ADR = 16'hC000,
    parameter int          DEPTH    = 8
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] adr_bus,
    input  logic        RW,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_strobe,
    output logic        irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          sel;
    logic [1:0]    off;
    logic          wr_data, rd_data, wr_ctrl;
    logic          tx_push_req, tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic          unused_counts;
    logic          ovf_clr;
    logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [1:0]    irq_en_q, irq_en_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_oe_q, data_oe_d;
    logic [7:0]    status;

    assign sel     = (adr_bus[15:2] == BASE_ADR[15:2]);
    assign off     = adr_bus[1:0];
    assign wr_data = sel & ~RW & (off == OFF_DATA);
    assign rd_data = sel &  RW & (off == OFF_DATA);
    assign wr_ctrl = sel & ~RW & (off == OFF_CTRL);
    assign ovf_clr = wr_ctrl & data_in[CTRL_OVF_CLR];

    // TX: bus pushes, consumer pops. A pop on the same edge makes room.
    assign tx_valid    = ~tx_empty;
    assign tx_pop      = tx_valid & tx_ready;
    assign tx_push_req = wr_data;
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);

    // RX: strobe pushes, DATA read pops; reading an empty RX is a no-op.
    assign rx_pop  = rd_data & ~rx_empty;
    assign rx_push = rx_strobe & (~rx_full | rx_pop);

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (tx_push),
        .din     (data_in),
        .pop     (tx_pop),
        .dout    (tx_data),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (rx_push),
        .din     (rx_data),
        .pop     (rx_pop),
        .dout    (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    assign unused_counts = ^{tx_count, rx_count};

    always_comb begin
        status                 = 8'h00;
        status[ST_RX_NONEMPTY] = ~rx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_TX_OVF]      = tx_ovf_q;
        status[ST_RX_OVF]      = rx_ovf_q;
    end

    always_comb begin
        // Set wins over clear so an overflow on the clearing edge is not lost.
        tx_ovf_d = (tx_ovf_q & ~ovf_clr) | (tx_push_req & tx_full & ~tx_pop);
        rx_ovf_d = (rx_ovf_q & ~ovf_clr) | (rx_strobe & rx_full & ~rx_pop);

        irq_en_d = irq_en_q;
        if (wr_ctrl) irq_en_d = {data_in[CTRL_IRQ_EN_TXEMPTY], data_in[CTRL_IRQ_EN_RX]};

        data_oe_d  = sel & RW;
        data_out_d = data_out_q;
        if (sel & RW) begin
            case (off)
                OFF_DATA:   data_out_d = rx_empty ? 8'h00 : rx_head;
                OFF_STATUS: data_out_d = status;
                OFF_CTRL:   data_out_d = {6'b0, irq_en_q};
                default:    data_out_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            irq_en_q   <= 2'b00;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
        end else begin
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            irq_en_q   <= irq_en_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign irq      = (irq_en_q[CTRL_IRQ_EN_RX] & ~rx_empty) |
                      (irq_en_q[CTRL_IRQ_EN_TXEMPTY] & tx_empty);

endmodule

// File: tb/tb_bus_io_port.sv
module tb_bus_io_port;
    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] adr_bus = 16'h0000;
    logic        RW = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_strobe = 1'b0;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    bus_io_port #(.BASE_ADR(16'hC000), .DEPTH(8)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .adr_bus   (adr_bus),
        .RW        (RW),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive on negedge, exactly one posedge, return to idle 1ns after it.
    task automatic step(input logic [15:0] a, input logic rw, input logic [7:0] d,
                        input logic txr, input logic rxs, input logic [7:0] rxd);
        @(negedge clk);
        adr_bus = a; RW = rw; data_in = d;
        tx_ready = txr; rx_strobe = rxs; rx_data = rxd;
        @(posedge clk);
        #1;
        adr_bus = 16'h0000; RW = 1'b1; data_in = 8'h00;
        tx_ready = 1'b0; rx_strobe = 1'b0; rx_data = 8'h00;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        step(a, 1'b0, d, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [15:0] a);
        step(a, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle(input logic txr, input logic rxs, input logic [7:0] rxd);
        step(16'h0000, 1'b1, 8'h00, txr, rxs, rxd);
    endtask

    initial begin
        // Reset values while held in reset
        #12;
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_oe", data_oe, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_irq", irq, 1'b0);
        @(negedge clk); n_reset = 1'b1;

        // STATUS after reset
        rd(16'hC001);
        chk("status_after_rst", data_out, 8'h04);
        chk("status_oe", data_oe, 1'b1);
        chk("irq_after_rst", irq, 1'b0);
        idle(1'b0, 1'b0, 8'h00);
        chk("oe_drops", data_oe, 1'b0);
        chk("data_out_holds", data_out, 8'h04);

        // Two TX writes, then drain
        wr(16'hC000, 8'hA5);
        wr(16'hC000, 8'h3C);
        chk("tx_valid_2", tx_valid, 1'b1);
        chk("tx_head_a5", tx_data, 8'hA5);
        idle(1'b1, 1'b0, 8'h00);
        chk("tx_head_3c", tx_data, 8'h3C);
        idle(1'b1, 1'b0, 8'h00);
        chk("tx_drained", tx_valid, 1'b0);
        rd(16'hC001);
        chk("status_tx_empty", data_out, 8'h04);

        // Overfill TX
        for (int i = 1; i <= 9; i++) wr(16'hC000, 8'(i));
        rd(16'hC001);
        chk("status_tx_full_ovf", data_out, 8'h12);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("tx_drain_%0d", i), tx_data, 8'(i));
            idle(1'b1, 1'b0, 8'h00);
        end
        chk("tx_after_drain", tx_valid, 1'b0);
        wr(16'hC002, 8'h80);
        rd(16'hC001);
        chk("status_ovf_cleared", data_out, 8'h04);

        // RX interrupt and DATA reads
        wr(16'hC002, 8'h01);
        chk("irq_rx_empty", irq, 1'b0);
        rd(16'hC002);
        chk("ctrl_readback", data_out, 8'h01);
        rd(16'hC003);
        chk("reserved_reads_0", data_out, 8'h00);
        idle(1'b0, 1'b1, 8'h5A);
        chk("irq_rx", irq, 1'b1);
        rd(16'hC000);
        chk("rx_read_5a", data_out, 8'h5A);
        chk("irq_after_pop", irq, 1'b0);
        rd(16'hC000);
        chk("rx_read_empty", data_out, 8'h00);

        // Fill RX, then push-with-pop on full
        for (int i = 0; i < 8; i++) idle(1'b0, 1'b1, 8'(8'h10 + i));
        rd(16'hC001);
        chk("status_rx_full", data_out, 8'h0D);
        step(16'hC000, 1'b1, 8'h00, 1'b0, 1'b1, 8'hEE);
        chk("rx_full_pop_push", data_out, 8'h10);
        rd(16'hC001);
        chk("status_no_ovf", data_out, 8'h0D);
        idle(1'b0, 1'b1, 8'hFF);
        rd(16'hC001);
        chk("status_rx_ovf", data_out, 8'h2D);
        step(16'hC002, 1'b0, 8'h81, 1'b0, 1'b1, 8'hFF);
        rd(16'hC001);
        chk("ovf_sticky_vs_clr", data_out, 8'h2D);
        wr(16'hC002, 8'h81);
        rd(16'hC001);
        chk("ovf_cleared", data_out, 8'h0D);
        for (int i = 0; i < 8; i++) begin
            rd(16'hC000);
            chk($sformatf("rx_order_%0d", i), data_out, (i == 7) ? 8'hEE : 8'(8'h11 + i));
        end
        rd(16'hC001);
        chk("status_all_empty", data_out, 8'h04);
        chk("irq_rx_drained", irq, 1'b0);

        // Asynchronous reset mid-stream
        idle(1'b0, 1'b1, 8'h77);
        wr(16'hC000, 8'h42);
        rd(16'hC001);
        chk("pre_rst_status", data_out, 8'h01);
        chk("pre_rst_tx_valid", tx_valid, 1'b1);
        chk("pre_rst_irq", irq, 1'b1);
        @(negedge clk);
        adr_bus = 16'hC001; RW = 1'b1;
        #2 n_reset = 1'b0;
        #1;
        chk("async_data_out", data_out, 8'h00);
        chk("async_data_oe", data_oe, 1'b0);
        chk("async_tx_valid", tx_valid, 1'b0);
        chk("async_irq", irq, 1'b0);
        @(posedge clk); #1;
        chk("held_data_oe", data_oe, 1'b0);
        @(negedge clk);
        n_reset = 1'b1; adr_bus = 16'h0000;
        rd(16'hC001);
        chk("status_after_async", data_out, 8'h04);
        chk("irq_after_async", irq, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/bus_io_port.md
Name: bus_io_port

Overview:
Memory-mapped byte I/O responder on the CPU's parallel bus. It is the target side of the cycles the CPU initiates. It decodes a 4-byte window and exposes a TX FIFO, drained by an external consumer through valid/ready, and an RX FIFO, filled by external strobes. Both FIFOs are reachable through DATA/STATUS/CTRL registers, with a level interrupt output. It sits beside RAM/ROM on the CPU address/data bus.

Parameters:
BASE_ADR, 16'hC000, window base; bits [1:0] ignored (must be 0)
DEPTH, 8, entries per FIFO; power of two, 2..256

Ports:
clk  in  1  system clock; all state updates on posedge (CPU drives bus on negedge)
n_reset  in  1  asynchronous, active-low reset
adr_bus  in  16  CPU address
RW  in  1  1 = CPU read, 0 = CPU write
data_in  in  8  CPU write data (CPU data_bus_out)
data_out  out  8  read data to CPU (registered)
data_oe  out  1  high when data_out must drive the CPU data_bus_in mux
tx_data  out  8  TX FIFO head
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  consumer accepts tx_data this cycle
rx_data  in  8  incoming byte
rx_strobe  in  1  one-cycle push of rx_data; no backpressure
irq  out  1  level interrupt

Behaviour:
- sel = (adr_bus[15:2] == BASE_ADR[15:2]). One bus cycle equals one clock; side effects occur exactly once per posedge with sel.
- Offsets: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved (reads 0x00, writes ignored).
- DATA write (sel, RW=0, off 0): push data_in to TX. If TX is full and the consumer is not popping in the same cycle, the byte is dropped and tx_ovf is set.
- DATA read (sel, RW=1, off 0): data_out <= RX head and RX pops on the same edge. If RX is empty: data_out <= 8'h00, no pop, no flag.
- STATUS (read-only): [0] rx_nonempty, [1] tx_full, [2] tx_empty, [3] rx_full, [4] tx_ovf, [5] rx_ovf, [7:6] 0. Values are the pre-edge state.
- CTRL: [0] irq_en_rx, [1] irq_en_txempty, [7] write-1 clears tx_ovf and rx_ovf (not stored; reads 0). Bits [6:2] read 0.
- Read timing: data_out and data_oe are registered at the posedge where the address is sampled. They are valid half a cycle before the CPU's sampling negedge. data_oe <= sel & RW; otherwise data_out holds its value and data_oe=0.
- TX drain: a pop occurs on posedge when tx_valid & tx_ready. tx_data is the head, stable while tx_valid and not popped.
- RX fill: on rx_strobe, push rx_data. If RX is full (and not popped in the same cycle by a DATA read), the byte is dropped and rx_ovf is set.
- Simultaneous push and pop on a full FIFO: both take effect and the count is unchanged, with no overflow. A simultaneous push and pop on an empty FIFO cannot occur.
- Sticky flags: an overflow set and a CTRL clear in the same cycle -> flag ends set.
- irq = (irq_en_rx & rx_nonempty) | (irq_en_txempty & tx_empty). It is derived from registers only, with no combinational path from bus inputs.
- Reset (async, n_reset=0): both FIFOs empty, pointers/counts 0, flags 0, CTRL 0, data_out=8'h00, data_oe=0, tx_valid=0, irq=0. A bus cycle in progress at reset is abandoned with no partial side effect.
- Counts are log2(DEPTH)+1 bits wide and pointers wrap modulo DEPTH.

Decomposition:
- Package io_port_pkg: register offsets (OFF_DATA=0, OFF_STATUS=1, OFF_CTRL=2), STATUS and CTRL bit indices.
- Sub-module byte_fifo (params DEPTH): push/pop/din/dout/full/empty/count with same-cycle push-on-full-with-pop semantics. It is instanced twice (TX, RX).

Test Plan:
- Reset then read 16'hC001 -> data_out=8'h04 (tx_empty), data_oe=1 for that cycle; irq=0.
- Write 8'hA5, 8'h3C to 16'hC000 with tx_ready=0 -> tx_valid=1, tx_data=8'hA5. Raise tx_ready for 2 cycles -> A5 then 3C consumed, tx_valid=0, STATUS[2]=1.
- Write 9 bytes 8'h01..8'h09 with tx_ready=0 (DEPTH=8) -> STATUS=8'h12 (tx_full, tx_ovf). Drain yields 01..08. Write 8'h80 to 16'hC002 -> STATUS[4]=0.
- Set CTRL=8'h01, pulse rx_strobe with 8'h5A -> irq=1 next cycle. Read 16'hC000 -> 8'h5A, irq=0 after pop. Read again -> 8'h00.
- Fill RX with 8 bytes, then same cycle rx_strobe=8'hEE plus DATA read -> read returns first byte, EE accepted, rx_ovf=0, RX still full.
- Assert n_reset=0 mid-stream with both FIFOs partially full -> all outputs at reset values immediately (async), STATUS reads 8'h04 after release.
